// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ data packer.
// Holds the packer state encoding, the data width and the default run header.
package daq_pkg;

    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] HEADER_WORD_DEF = 16'hFF80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } packer_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/daq_data_packer_if.sv
// Bundle of the DAQ-side and USB-side signals of the packer.
// The slave modport is the packer's view; master is the view of whatever drives it.
interface daq_data_packer_if;
    import daq_pkg::*;

    logic              ModuleStart;
    logic [DATA_W-1:0] SlaveDaqData;
    logic              SlaveDaqData_en;
    logic              AllDone;
    logic              UsbFifoFull;
    logic [DATA_W-1:0] UsbData;
    logic              UsbData_en;
    logic              DataTransmitDone;
    logic              Overflow;
    logic [15:0]       DroppedCount;
    logic [31:0]       WordCount;

    modport slave (
        input  ModuleStart, SlaveDaqData, SlaveDaqData_en, AllDone, UsbFifoFull,
        output UsbData, UsbData_en, DataTransmitDone, Overflow, DroppedCount, WordCount
    );

    modport master (
        output ModuleStart, SlaveDaqData, SlaveDaqData_en, AllDone, UsbFifoFull,
        input  UsbData, UsbData_en, DataTransmitDone, Overflow, DroppedCount, WordCount
    );

endinterface

// File: rtl/daq_data_packer_sync_fifo.sv
// Single-clock FIFO with a registered read port suited to block RAM inference.
// Pointers carry one extra bit so full and empty differ only in the MSB.
module sync_fifo #(
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_rd_data;
    logic          w_do_wr;
    logic          w_do_rd;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_rd_data;
    assign w_do_wr   = i_wr_en && !o_full;
    assign w_do_rd   = i_rd_en && !o_empty;

    // Storage kept free of reset so it maps onto RAM primitives.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/daq_data_packer.sv
// Buffers the DAQ word stream, prefixes each run with a header and drains it to USB.
// The FIFO read register doubles as the output holding register; r_out_valid marks it full.
module daq_data_packer
    import daq_pkg::*;
#(
    parameter int                FIFO_AW     = 9,
    parameter logic [DATA_W-1:0] HEADER_WORD = HEADER_WORD_DEF
) (
    input  logic             Clk,
    input  logic             reset_n,
    daq_data_packer_if.slave bus
);

    packer_state_t     r_state;
    packer_state_t     w_state_next;
    logic              r_ms;
    logic              r_ms_d;
    logic              r_out_valid;
    logic              r_overflow;
    logic [15:0]       r_dropped;
    logic [31:0]       r_word_count;
    logic              w_rise;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;
    logic              w_clear;
    logic              w_drop;
    logic              w_emit;
    logic              w_fifo_rd;
    logic [DATA_W-1:0] w_fifo_q;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FIFO_AW:0]  w_fifo_count;

    assign w_rise    = r_ms && !r_ms_d;
    assign w_drop    = w_push && w_fifo_full;
    assign w_emit    = r_out_valid && !bus.UsbFifoFull;
    assign w_fifo_rd = !w_fifo_empty && (!r_out_valid || w_emit);

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_push_data  = bus.SlaveDaqData;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_push       = 1'b1;
                    w_push_data  = HEADER_WORD;
                    w_clear      = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_push = bus.SlaveDaqData_en;
                if (bus.AllDone) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_push = bus.SlaveDaqData_en;
                // A late strobe this cycle must still be drained before finishing.
                if ((w_fifo_count == '0) && !r_out_valid && !w_push) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (!bus.AllDone) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_ms         <= 1'b0;
            r_ms_d       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_dropped    <= '0;
            r_word_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_ms    <= bus.ModuleStart;
            r_ms_d  <= r_ms;
            if (w_fifo_rd) begin
                r_out_valid <= 1'b1;
            end else if (w_emit) begin
                r_out_valid <= 1'b0;
            end
            if (w_clear) begin
                r_overflow   <= 1'b0;
                r_dropped    <= '0;
                r_word_count <= '0;
            end else begin
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    r_dropped  <= sat_inc16(r_dropped);
                end
                if (w_emit) begin
                    r_word_count <= r_word_count + 32'd1;
                end
            end
        end
    end

    sync_fifo #(
        .DW (DATA_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk     (Clk),
        .i_rst_n   (reset_n),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_data),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_fifo_q),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign bus.UsbData          = w_fifo_q;
    assign bus.UsbData_en       = w_emit;
    assign bus.DataTransmitDone = (r_state == DONE) && bus.AllDone;
    assign bus.Overflow         = r_overflow;
    assign bus.DroppedCount     = r_dropped;
    assign bus.WordCount        = r_word_count;

endmodule

// File: tb/tb_daq_data_packer.sv
// Scoreboard bench for daq_data_packer: stimulus queues expected USB words,
// a negedge monitor pops and compares every UsbData_en beat.
module tb_daq_data_packer;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    daq_data_packer_if bus();

    daq_data_packer #(
        .FIFO_AW     (9),
        .HEADER_WORD (16'hFF80)
    ) dut (
        .Clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [15:0] exp_q [$];
    logic [15:0] exp_w;
    int          n_checks      = 0;
    int          n_fail        = 0;
    int          emit_cnt      = 0;
    int          stall_emit    = 0;
    int          cyc           = 0;
    int          last_emit_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.UsbData_en === 1'b1) begin
            emit_cnt++;
            last_emit_cyc = cyc;
            if (bus.UsbFifoFull === 1'b1) stall_emit++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %04h, expected no word", bus.UsbData);
            end else begin
                exp_w = exp_q.pop_front();
                $display("usb word %04h expected %04h (cycle %0d)", bus.UsbData, exp_w, cyc);
                check("usb_data", {16'h0, bus.UsbData}, {16'h0, exp_w});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_en"},      {31'h0, bus.UsbData_en}, 32'h0);
        check({tag, "_data"},    {16'h0, bus.UsbData}, 32'h0);
        check({tag, "_done"},    {31'h0, bus.DataTransmitDone}, 32'h0);
        check({tag, "_ovf"},     {31'h0, bus.Overflow}, 32'h0);
        check({tag, "_dropped"}, {16'h0, bus.DroppedCount}, 32'h0);
        check({tag, "_wc"},      bus.WordCount, 32'h0);
    endtask

    task automatic start_run();
        bus.ModuleStart = 1'b0;
        tick();
        tick();
        bus.ModuleStart = 1'b1;
        exp_q.push_back(16'hFF80);
        repeat (3) tick();
    endtask

    task automatic send_words(input logic [15:0] base, input int n, input int nkeep, input bit alldone_on_last);
        for (int i = 0; i < n; i++) begin
            bus.SlaveDaqData    = base + 16'(i);
            bus.SlaveDaqData_en = 1'b1;
            if (alldone_on_last && (i == n - 1)) bus.AllDone = 1'b1;
            if (i < nkeep) exp_q.push_back(base + 16'(i));
            tick();
        end
        bus.SlaveDaqData_en = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int budget, input logic [31:0] exp_wc,
                              input logic [15:0] exp_dropped);
        bit found;
        found = 1'b0;
        bus.AllDone = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (bus.DataTransmitDone === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'h0, found}, 32'h1);
        check({tag, "_pending_at_done"}, exp_q.size(), 32'h0);
        check({tag, "_last_word_before_done"}, {31'h0, (cyc > last_emit_cyc)}, 32'h1);
        check({tag, "_done_gap"}, {31'h0, ((cyc - last_emit_cyc) <= 2)}, 32'h1);
        check({tag, "_word_count"}, bus.WordCount, exp_wc);
        check({tag, "_dropped"}, {16'h0, bus.DroppedCount}, {16'h0, exp_dropped});
        @(posedge clk);
        #1;
        bus.AllDone = 1'b0;
        #1;
        check({tag, "_done_fall"}, {31'h0, bus.DataTransmitDone}, 32'h0);
        tick();
        check({tag, "_done_idle"}, {31'h0, bus.DataTransmitDone}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int done_hi;
        bus.ModuleStart     = 1'b0;
        bus.SlaveDaqData    = 16'h0;
        bus.SlaveDaqData_en = 1'b0;
        bus.AllDone         = 1'b0;
        bus.UsbFifoFull     = 1'b0;

        // Reset state
        repeat (3) tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick();

        // 1: basic run, header plus 0001..000A
        start_run();
        send_words(16'h0001, 10, 10, 1'b0);
        finish_run("basic", 60, 32'd11, 16'd0);

        // 2: back-pressure for ~100 cycles while 50 words arrive
        bus.UsbFifoFull = 1'b1;
        e0 = emit_cnt;
        start_run();
        send_words(16'h0100, 50, 50, 1'b0);
        repeat (47) tick();
        check("stall_no_emit", emit_cnt - e0, 32'h0);
        check("stall_emit_while_full", stall_emit, 32'h0);
        bus.UsbFifoFull = 1'b0;
        finish_run("backpressure", 200, 32'd51, 16'd0);

        // 3: overflow, header in holding register, 512 in FIFO, 8 dropped
        bus.UsbFifoFull = 1'b1;
        start_run();
        send_words(16'h1000, 520, 512, 1'b0);
        check("ovf_dropped", {16'h0, bus.DroppedCount}, 32'd8);
        check("ovf_flag", {31'h0, bus.Overflow}, 32'h1);

        // 4: AllDone with full FIFO under back-pressure
        bus.AllDone = 1'b1;
        done_hi = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.DataTransmitDone === 1'b1) done_hi++;
        end
        check("full_done_held_low", done_hi, 32'h0);
        check("full_no_emit_word_count", bus.WordCount, 32'h0);
        bus.UsbFifoFull = 1'b0;
        finish_run("full_drain", 1000, 32'd513, 16'd8);

        // 5: next start clears Overflow; AllDone coincides with the last strobe
        start_run();
        check("restart_ovf_clear", {31'h0, bus.Overflow}, 32'h0);
        check("restart_dropped_clear", {16'h0, bus.DroppedCount}, 32'h0);
        send_words(16'h2000, 5, 5, 1'b1);
        finish_run("coincide", 60, 32'd6, 16'd0);

        // 6: reset with 30 words buffered
        bus.UsbFifoFull = 1'b1;
        start_run();
        send_words(16'h3000, 30, 0, 1'b0);
        bus.ModuleStart = 1'b0;
        reset_n = 1'b0;
        tick();
        bus.UsbFifoFull = 1'b0;
        tick();
        exp_q.delete();
        check_outputs_zero("midrun_reset");
        e0 = emit_cnt;
        reset_n = 1'b1;
        repeat (20) tick();
        check("post_reset_no_emit", emit_cnt - e0, 32'h0);
        start_run();
        send_words(16'h4000, 2, 2, 1'b0);
        finish_run("after_reset", 60, 32'd3, 16'd0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
